// File: rtl/br_amba_pkg.sv
// Shared AXI encodings and helpers for the br_amba subordinate-side blocks.
package br_amba_pkg;

    localparam int AxiBurstLenWidth   = 8;
    localparam int AxiBurstSizeWidth  = 3;
    localparam int Axi4kBoundaryWidth = 12;
    localparam int AxiMaxFixedLen     = 16;

    typedef enum logic [1:0] {
        AxiBurstFixed    = 2'b00,
        AxiBurstIncr     = 2'b01,
        AxiBurstWrap     = 2'b10,
        AxiBurstReserved = 2'b11
    } axi_burst_type_t;

    typedef enum logic [1:0] {
        AxiRespOkay   = 2'b00,
        AxiRespExokay = 2'b01,
        AxiRespSlverr = 2'b10,
        AxiRespDecerr = 2'b11
    } axi_resp_t;

    function automatic logic is_legal_wrap_len(input logic [AxiBurstLenWidth-1:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/br_amba_axi_beat_addr_calc.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared by read and write paths.
module br_amba_axi_beat_addr_calc
    import br_amba_pkg::*;
#(
    parameter int AddrWidth = 40
) (
    input  logic [AddrWidth-1:0]         cur_addr_i,
    input  logic [AxiBurstSizeWidth-1:0] size_i,
    input  logic [1:0]                   burst_i,
    input  logic [AddrWidth-1:0]         wrap_lower_i,
    input  logic [AddrWidth-1:0]         wrap_wbytes_i,
    output logic [AddrWidth-1:0]         next_addr_o
);

    logic [AddrWidth-1:0] bytes;
    logic [AddrWidth-1:0] aligned;
    logic [AddrWidth-1:0] incr_addr;
    logic [AddrWidth-1:0] wrap_step;

    assign bytes     = AddrWidth'(1) << size_i;
    assign aligned   = cur_addr_i & ~(bytes - AddrWidth'(1));
    // INCR steps from the aligned address so an unaligned beat 0 snaps onto the grid.
    assign incr_addr = aligned + bytes;
    assign wrap_step = cur_addr_i + bytes;

    always_comb begin
        next_addr_o = cur_addr_i;
        case (axi_burst_type_t'(burst_i))
            AxiBurstIncr: next_addr_o = incr_addr;
            AxiBurstWrap: next_addr_o = (wrap_step == wrap_lower_i + wrap_wbytes_i) ?
                                        wrap_lower_i : wrap_step;
            default:      next_addr_o = cur_addr_i;
        endcase
    end

endmodule

// File: rtl/br_amba_axi_burst_addr_gen.sv
// Expands one AXI AR/AW command into a stream of per-beat addresses, flagging illegal
// commands with SLVERR on every beat.
module br_amba_axi_burst_addr_gen
    import br_amba_pkg::*;
#(
    parameter int AddrWidth = 40,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [AddrWidth-1:0]         cmd_addr,
    input  logic [IdWidth-1:0]           cmd_id,
    input  logic [AxiBurstLenWidth-1:0]  cmd_len,
    input  logic [AxiBurstSizeWidth-1:0] cmd_size,
    input  logic [1:0]                   cmd_burst,
    output logic                         beat_valid,
    input  logic                         beat_ready,
    output logic [AddrWidth-1:0]         beat_addr,
    output logic [IdWidth-1:0]           beat_id,
    output logic [AxiBurstLenWidth-1:0]  beat_idx,
    output logic [AxiBurstSizeWidth-1:0] beat_size,
    output logic                         beat_last,
    output logic [1:0]                   beat_resp
);

    localparam logic [AxiBurstSizeWidth-1:0] MaxSize = AxiBurstSizeWidth'($clog2(DataWidth / 8));
    localparam int SpanWidth = 20;
    localparam logic [SpanWidth-1:0] PageBytes = SpanWidth'(1) << Axi4kBoundaryWidth;

    typedef enum logic {StIdle, StBusy} state_t;

    state_t                         state_q, state_d;
    logic                           beat_valid_q, beat_valid_d;
    logic [AddrWidth-1:0]           beat_addr_q, beat_addr_d;
    logic [IdWidth-1:0]             beat_id_q, beat_id_d;
    logic [AxiBurstLenWidth-1:0]    beat_idx_q, beat_idx_d;
    logic [AxiBurstSizeWidth-1:0]   beat_size_q, beat_size_d;
    logic                           beat_last_q, beat_last_d;
    logic [1:0]                     beat_resp_q, beat_resp_d;
    logic [AxiBurstLenWidth-1:0]    len_q, len_d;
    logic [1:0]                     burst_q, burst_d;
    logic                           err_q, err_d;
    logic [AddrWidth-1:0]           lower_q, lower_d;
    logic [AddrWidth-1:0]           wbytes_q, wbytes_d;

    logic                           cmd_hs;
    logic                           beat_hs;
    logic                           cmd_err;
    logic [AddrWidth-1:0]           cmd_wbytes;
    logic [AddrWidth-1:0]           cmd_lower;
    logic [Axi4kBoundaryWidth-1:0]  bytes_4k;
    logic [Axi4kBoundaryWidth-1:0]  aligned_4k;
    logic [SpanWidth-1:0]           span_end;
    logic [1:0]                     calc_burst;
    logic [AddrWidth-1:0]           next_addr;

    // Legality is judged once, on the command as presented.
    assign bytes_4k   = Axi4kBoundaryWidth'(1) << cmd_size;
    assign aligned_4k = cmd_addr[Axi4kBoundaryWidth-1:0] & ~(bytes_4k - Axi4kBoundaryWidth'(1));
    assign span_end   = SpanWidth'(aligned_4k) + ((SpanWidth'(cmd_len) + SpanWidth'(1)) << cmd_size);
    assign cmd_wbytes = (AddrWidth'(cmd_len) + AddrWidth'(1)) << cmd_size;
    assign cmd_lower  = cmd_addr & ~(cmd_wbytes - AddrWidth'(1));

    always_comb begin
        cmd_err = 1'b0;
        case (axi_burst_type_t'(cmd_burst))
            AxiBurstFixed: cmd_err = (cmd_len >= AxiBurstLenWidth'(AxiMaxFixedLen));
            AxiBurstIncr:  cmd_err = (span_end > PageBytes);
            AxiBurstWrap:  cmd_err = !is_legal_wrap_len(cmd_len) ||
                                     ((cmd_addr[Axi4kBoundaryWidth-1:0] &
                                       (bytes_4k - Axi4kBoundaryWidth'(1))) != '0);
            default:       cmd_err = 1'b1;
        endcase
        if (cmd_size > MaxSize) begin
            cmd_err = 1'b1;
        end
    end

    // An erroring burst walks as FIXED so every beat stays on cmd_addr.
    assign calc_burst = err_q ? AxiBurstFixed : burst_q;

    br_amba_axi_beat_addr_calc #(
        .AddrWidth (AddrWidth)
    ) u_addr_calc (
        .cur_addr_i    (beat_addr_q),
        .size_i        (beat_size_q),
        .burst_i       (calc_burst),
        .wrap_lower_i  (lower_q),
        .wrap_wbytes_i (wbytes_q),
        .next_addr_o   (next_addr)
    );

    assign beat_hs   = beat_valid_q && beat_ready;
    assign cmd_ready = rst_n && ((state_q == StIdle) || (beat_hs && beat_last_q));
    assign cmd_hs    = cmd_valid && cmd_ready;

    always_comb begin
        state_d      = state_q;
        beat_valid_d = beat_valid_q;
        beat_addr_d  = beat_addr_q;
        beat_id_d    = beat_id_q;
        beat_idx_d   = beat_idx_q;
        beat_size_d  = beat_size_q;
        beat_last_d  = beat_last_q;
        beat_resp_d  = beat_resp_q;
        len_d        = len_q;
        burst_d      = burst_q;
        err_d        = err_q;
        lower_d      = lower_q;
        wbytes_d     = wbytes_q;
        if (cmd_hs) begin
            state_d      = StBusy;
            beat_valid_d = 1'b1;
            beat_addr_d  = cmd_addr;
            beat_id_d    = cmd_id;
            beat_idx_d   = '0;
            beat_size_d  = cmd_size;
            beat_last_d  = (cmd_len == '0);
            beat_resp_d  = cmd_err ? AxiRespSlverr : AxiRespOkay;
            len_d        = cmd_len;
            burst_d      = cmd_burst;
            err_d        = cmd_err;
            lower_d      = cmd_lower;
            wbytes_d     = cmd_wbytes;
        end else if (beat_hs) begin
            if (beat_last_q) begin
                state_d      = StIdle;
                beat_valid_d = 1'b0;
            end else begin
                beat_addr_d = next_addr;
                beat_idx_d  = beat_idx_q + AxiBurstLenWidth'(1);
                beat_last_d = ((beat_idx_q + AxiBurstLenWidth'(1)) == len_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            beat_valid_q <= 1'b0;
            beat_addr_q  <= '0;
            beat_id_q    <= '0;
            beat_idx_q   <= '0;
            beat_size_q  <= '0;
            beat_last_q  <= 1'b0;
            beat_resp_q  <= '0;
            len_q        <= '0;
            burst_q      <= '0;
            err_q        <= 1'b0;
            lower_q      <= '0;
            wbytes_q     <= '0;
        end else begin
            state_q      <= state_d;
            beat_valid_q <= beat_valid_d;
            beat_addr_q  <= beat_addr_d;
            beat_id_q    <= beat_id_d;
            beat_idx_q   <= beat_idx_d;
            beat_size_q  <= beat_size_d;
            beat_last_q  <= beat_last_d;
            beat_resp_q  <= beat_resp_d;
            len_q        <= len_d;
            burst_q      <= burst_d;
            err_q        <= err_d;
            lower_q      <= lower_d;
            wbytes_q     <= wbytes_d;
        end
    end

    assign beat_valid = beat_valid_q;
    assign beat_addr  = beat_addr_q;
    assign beat_id    = beat_id_q;
    assign beat_idx   = beat_idx_q;
    assign beat_size  = beat_size_q;
    assign beat_last  = beat_last_q;
    assign beat_resp  = beat_resp_q;

endmodule
